// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO; frames are sent gap-free while data is queued.
// Define UART_TX_PARITY_EN to compile in the optional parity bit (parity_en/parity_odd are ignored otherwise).
module uart_tx_fifo #(
  parameter int CLK_SPEED  = 12000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 full,
  output logic                 empty,
  output logic [LW-1:0]        level,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx
);

  localparam int BIT_CYCLES  = CLK_SPEED / BAUD_RATE;
  localparam int STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int CW          = $clog2(STOP_CYCLES);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int IW          = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        count_q, count_d;
  logic                 full_q, empty_q, overflow_q;
  logic                 push_s, pop_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q, busy_q;
  logic                 bit_end_s, stop_end_s;

`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_bit_q;
`else
  logic                 unused_parity_s;
  assign unused_parity_s = parity_en ^ parity_odd;
`endif

  assign push_s     = wr_en && !full_q;
  assign head_s     = mem_q[rd_ptr_q];
  assign bit_end_s  = (cnt_q == CW'(BIT_CYCLES - 1));
  assign stop_end_s = (cnt_q == CW'(STOP_CYCLES - 1));

  // Pop the head entry whenever a new frame can start: from idle or at the very end of a stop period.
  always_comb begin
    pop_s = 1'b0;
    if (!empty_q && (state_q == S_IDLE || (state_q == S_STOP && stop_end_s))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers and registered status; flags derive from the same next count so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == LW'(FIFO_DEPTH));
      empty_q <= (count_d == LW'(0));
      if (wr_en && full_q) overflow_q <= 1'b1;
    end
  end

  // Transmit FSM with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      // Frame settings are captured at pop time so later input changes cannot disturb it.
      if (pop_s) begin
        shift_q <= head_s;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= parity_en;
        par_bit_q <= (^head_s) ^ parity_odd;
`endif
      end
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!empty_q) begin
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            cnt_q <= '0;
            if (bit_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q   <= bit_q + IW'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_s) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (stop_end_s) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (!empty_q) begin
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a line monitor decodes and compares them.
module tb_uart_tx_fifo;

  localparam int CS    = 1000;
  localparam int BR    = 190;
  localparam int BC    = CS / BR;
  localparam int DB    = 7;
  localparam int SB    = 2;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, wr_en, parity_en, parity_odd;
  logic [DB-1:0] wr_data;
  logic          full, empty, overflow, busy, tx;
  logic [LW-1:0] level;

  typedef struct {
    logic [DB-1:0] d;
    bit            pen;
    bit            podd;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     in_frame = 1'b0;

  uart_tx_fifo #(
    .CLK_SPEED (CS),
    .BAUD_RATE (BR),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int flen(input bit pen);
    return (1 + DB + ((PAR_BUILT && pen) ? 1 : 0) + SB) * BC;
  endfunction

  // Line monitor: decode every frame cycle by cycle against the oldest expected frame.
  initial begin
    frame_t cur;
    bit     bits[16];
    int     nb, len, nbad, nbusy, k;
    bit     aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          k = 0;
          while (tx === 1'b0 && k < 1000) begin @(negedge clk); k++; end
        end else begin
          cur = exp_q.pop_front();
          nb = 0;
          bits[nb++] = 1'b0;
          for (int i = 0; i < DB; i++) bits[nb++] = cur.d[i];
          if (PAR_BUILT && cur.pen) bits[nb++] = (^cur.d) ^ cur.podd;
          for (int i = 0; i < SB; i++) bits[nb++] = 1'b1;
          len = nb * BC;
          nbad = 0; nbusy = 0; aborted = 1'b0; in_frame = 1'b1;
          for (int j = 0; j < len; j++) begin
            if (j > 0) @(negedge clk);
            if (rst !== 1'b0) begin aborted = 1'b1; break; end
            if (tx !== bits[j / BC]) nbad++;
            if (busy !== 1'b1) nbusy++;
          end
          in_frame = 1'b0;
          if (!aborted) begin
            chk($sformatf("frame_line data=%0h bad_cycles", cur.d), nbad, 0);
            chk($sformatf("frame_busy data=%0h low_cycles", cur.d), nbusy, 0);
          end
        end
      end
    end
  end

  task automatic push(input logic [DB-1:0] d, input bit pen, input bit podd);
    frame_t f;
    wr_en = 1'b1; wr_data = d; parity_en = pen; parity_odd = podd;
    f.d = d; f.pen = pen; f.podd = podd;
    exp_q.push_back(f);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Count busy cycles of one activity burst and track peak level; optionally flip parity_odd mid-burst.
  task automatic watch(input int toggle_at, output int bn, output int lmax);
    int k;
    bit seen;
    k = 0; seen = 1'b0; bn = 0; lmax = 0;
    while (k < 20000) begin
      @(negedge clk); k++;
      if (int'(level) > lmax) lmax = int'(level);
      if (busy === 1'b1) begin
        seen = 1'b1; bn++;
        if (bn == toggle_at) parity_odd = ~parity_odd;
      end else if (seen) begin
        break;
      end
    end
    chk("watch_timeout", (k < 20000) ? 1 : 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end
    while ((exp_q.size() != 0 || in_frame || busy !== 1'b0) && k < 20000);
    chk("drain_timeout", (k < 20000) ? 1 : 0, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bn, lm, nbad, gap;
    logic [DB-1:0] d;
    bit rp_en, rp_odd;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_full", full, 0);
    chk("reset_empty", empty, 1);
    chk("reset_level", level, 0);
    chk("reset_overflow", overflow, 0);

    // Single frame: one-cycle latency and exact busy length.
    fork
      watch(-1, bn, lm);
      begin
        push(7'h55, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_tx_before", tx, 1);
        chk("lat_level_one", level, 1);
        chk("lat_empty_zero", empty, 0);
        @(negedge clk);
        chk("lat_tx_low", tx, 0);
        chk("lat_busy", busy, 1);
        chk("lat_level_popped", level, 0);
        chk("lat_empty_again", empty, 1);
      end
    join
    chk("single_busy_len", bn, flen(1'b0));
    drain();

    // Back-to-back frames without idle gap.
    fork
      watch(-1, bn, lm);
      begin
        push(7'h01, 1'b0, 1'b0);
        push(7'h02, 1'b0, 1'b0);
        push(7'h03, 1'b0, 1'b0);
      end
    join
    chk("b2b_busy_len", bn, 3 * flen(1'b0));
    chk("b2b_level_peak", lm, 2);
    chk("b2b_level_end", level, 0);
    drain();

    // Parity latched at pop; a mid-frame parity_odd flip has no effect.
    fork
      watch(3 * BC, bn, lm);
      push(7'h07, 1'b1, 1'b0);
    join
    chk("par_even_len", bn, flen(1'b1));
    drain();
    fork
      watch(3 * BC, bn, lm);
      push(7'h07, 1'b1, 1'b1);
    join
    chk("par_odd_len", bn, flen(1'b1));
    drain();
    parity_en = 1'b0; parity_odd = 1'b0;

    // Overflow: DEPTH+2 consecutive pushes from idle, the last one is dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      frame_t f;
      d = DB'($urandom);
      wr_en = 1'b1; wr_data = d;
      if (i <= DEPTH) begin
        f.d = d; f.pen = 1'b0; f.podd = 1'b0;
        exp_q.push_back(f);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, DEPTH);
    drain();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_full_cleared", full, 0);
    chk("ovf_empty", empty, 1);

    // Randomised traffic with fixed random parity settings.
    rp_en = 1'($urandom_range(0, 1));
    rp_odd = 1'($urandom_range(0, 1));
    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : 0;
      repeat (gap) @(posedge clk);
      #1;
      if (exp_q.size() < DEPTH) push(DB'($urandom), rp_en, rp_odd);
      else begin @(posedge clk); #1; end
    end
    drain();
    parity_en = 1'b0; parity_odd = 1'b0;

    // Reset during data bit 3 with four entries still queued.
    for (int i = 0; i < 5; i++) push(DB'($urandom), 1'b0, 1'b0);
    repeat (18) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_overflow", overflow, 0);
    nbad = 0;
    for (int i = 0; i < 3 * flen(1'b0); i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) nbad++;
    end
    chk("rst_no_more_frames", nbad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
